// File: rtl/load_value_predictor.sv
// Stride / last-value load value predictor with a tagged direct-mapped table
// and an in-order queue of outstanding predictions awaiting their real data.
module load_value_predictor #(
  parameter int INDEX_WIDTH = 6,
  parameter int CONF_WIDTH  = 2,
  parameter int CONF_THRESH = 3,
  parameter int MAX_PENDING = 4,
  parameter int STRIDE_EN   = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vp_en,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  req_ready,
  output logic                  pred_valid,
  output logic                  pred_use,
  output logic [DATA_WIDTH-1:0] pred_data,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  flush,
  output logic                  en_recover,
  output logic [DATA_WIDTH-1:0] recover_data,
  output logic                  done
);

  localparam int ENTRIES   = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int PTR_WIDTH = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_WIDTH = $clog2(MAX_PENDING + 1);
  localparam logic [PTR_WIDTH-1:0]  PTR_LAST      = PTR_WIDTH'(MAX_PENDING - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL      = CNT_WIDTH'(MAX_PENDING);
  localparam logic [CONF_WIDTH:0]   CONF_THRESH_V = (CONF_WIDTH + 1)'(CONF_THRESH);
  localparam logic [CONF_WIDTH-1:0] CONF_MAX      = '1;

  logic                  tbl_valid  [ENTRIES];
  logic [TAG_WIDTH-1:0]  tbl_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] tbl_last   [ENTRIES];
  logic [DATA_WIDTH-1:0] tbl_stride [ENTRIES];
  logic [CONF_WIDTH-1:0] tbl_conf   [ENTRIES];

  logic [INDEX_WIDTH-1:0] q_index [MAX_PENDING];
  logic [TAG_WIDTH-1:0]   q_tag   [MAX_PENDING];
  logic [DATA_WIDTH-1:0]  q_pred  [MAX_PENDING];
  logic                   q_use   [MAX_PENDING];

  logic [PTR_WIDTH-1:0] head_q, tail_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic [INDEX_WIDTH-1:0] req_index;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   unused_pc_bits;
  logic                   full, pop, push;
  logic                   lk_hit, lk_use;
  logic [DATA_WIDTH-1:0]  lk_data;
  logic [INDEX_WIDTH-1:0] pop_index;
  logic [TAG_WIDTH-1:0]   pop_tag;
  logic [DATA_WIDTH-1:0]  pop_pred;
  logic                   pop_use, mismatch;
  logic                   tr_hit, tr_same;
  logic [DATA_WIDTH-1:0]  tr_new_stride;

  assign req_index      = req_pc[INDEX_WIDTH+1:2];
  assign req_tag        = req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_pc_bits = ^req_pc[1:0];

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign full      = (count_q == CNT_FULL);
  assign pop       = res_valid && (count_q != '0) && !flush;
  assign req_ready = !full || pop;
  assign push      = req_valid && req_ready && !flush;

  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Lookup sees the table as it was before this cycle's training write.
  always_comb begin
    lk_hit  = tbl_valid[req_index] && (tbl_tag[req_index] == req_tag);
    lk_data = '0;
    lk_use  = 1'b0;
    if (lk_hit) begin
      lk_data = (STRIDE_EN != 0) ? tbl_last[req_index] + tbl_stride[req_index]
                                 : tbl_last[req_index];
      lk_use  = vp_en && ({1'b0, tbl_conf[req_index]} >= CONF_THRESH_V);
    end
  end

  assign pop_index = q_index[head_q];
  assign pop_tag   = q_tag[head_q];
  assign pop_pred  = q_pred[head_q];
  assign pop_use   = q_use[head_q];
  assign mismatch  = pop_use && (res_data != pop_pred);

  always_comb begin
    tr_hit        = tbl_valid[pop_index] && (tbl_tag[pop_index] == pop_tag);
    tr_new_stride = res_data - tbl_last[pop_index];
    tr_same       = (STRIDE_EN != 0) ? (tr_new_stride == tbl_stride[pop_index])
                                     : (res_data == tbl_last[pop_index]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_last[i]   <= '0;
        tbl_stride[i] <= '0;
        tbl_conf[i]   <= '0;
      end
    end else if (pop) begin
      if (!tr_hit) begin
        tbl_valid[pop_index]  <= 1'b1;
        tbl_tag[pop_index]    <= pop_tag;
        tbl_last[pop_index]   <= res_data;
        tbl_stride[pop_index] <= '0;
        tbl_conf[pop_index]   <= '0;
      end else begin
        tbl_last[pop_index] <= res_data;
        if (tr_same) begin
          if (tbl_conf[pop_index] != CONF_MAX)
            tbl_conf[pop_index] <= tbl_conf[pop_index] + 1'b1;
        end else begin
          tbl_conf[pop_index] <= '0;
          if (STRIDE_EN != 0)
            tbl_stride[pop_index] <= tr_new_stride;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_index[tail_q] <= req_index;
      q_tag[tail_q]   <= req_tag;
      q_pred[tail_q]  <= lk_data;
      q_use[tail_q]   <= lk_use;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= ptr_next(tail_q);
      if (pop)  head_q <= ptr_next(head_q);
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (!push && pop)
        count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid   <= 1'b0;
      pred_use     <= 1'b0;
      pred_data    <= '0;
      en_recover   <= 1'b0;
      recover_data <= '0;
      done         <= 1'b0;
    end else begin
      pred_valid   <= push;
      pred_use     <= push && lk_use;
      pred_data    <= push ? lk_data : '0;
      en_recover   <= pop && mismatch;
      recover_data <= (pop && mismatch) ? res_data : '0;
      done         <= pop && !mismatch;
    end
  end

endmodule

// File: tb/tb_load_value_predictor.sv
// Directed bench for load_value_predictor: a queue/array reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_load_value_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vp_en = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        req_ready;
  logic        pred_valid, pred_use;
  logic [31:0] pred_data;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        flush = 1'b0;
  logic        en_recover;
  logic [31:0] recover_data;
  logic        done;

  int compared = 0;
  int mismatched = 0;

  load_value_predictor #(
    .INDEX_WIDTH(6), .CONF_WIDTH(2), .CONF_THRESH(3), .MAX_PENDING(4),
    .STRIDE_EN(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vp_en(vp_en),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .pred_valid(pred_valid), .pred_use(pred_use), .pred_data(pred_data),
    .res_valid(res_valid), .res_data(res_data), .flush(flush),
    .en_recover(en_recover), .recover_data(recover_data), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    bit          use_it;
  } pend_t;

  // Reference model: table keyed by pc[7:2], pending predictions in a queue.
  bit          m_valid  [64];
  logic [23:0] m_tag    [64];
  logic [31:0] m_last   [64];
  logic [31:0] m_stride [64];
  int          m_conf   [64];
  pend_t       mq[$];

  bit          exp_pred_valid, exp_pred_use, exp_en_recover, exp_done;
  logic [31:0] exp_pred_data, exp_recover_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = 0;
    end
    mq.delete();
    exp_pred_valid = 0; exp_pred_use = 0; exp_pred_data = '0;
    exp_en_recover = 0; exp_recover_data = '0; exp_done = 0;
  endtask

  task automatic modelTrain(input logic [31:0] pc, input logic [31:0] data);
    int          i;
    logic [31:0] ns;
    i = int'(pc[7:2]);
    if (!(m_valid[i] && m_tag[i] == pc[31:8])) begin
      m_valid[i] = 1'b1; m_tag[i] = pc[31:8];
      m_last[i] = data;  m_stride[i] = '0; m_conf[i] = 0;
    end else begin
      ns = data - m_last[i];
      if (ns == m_stride[i]) m_conf[i] = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
      else begin m_stride[i] = ns; m_conf[i] = 0; end
      m_last[i] = data;
    end
  endtask

  task automatic modelStep();
    int          occ, i;
    bit          do_pop, do_push, hit;
    pend_t       ent, p;
    occ     = mq.size();
    do_pop  = res_valid && occ > 0 && !flush;
    do_push = req_valid && (occ < 4 || do_pop) && !flush;
    i   = int'(req_pc[7:2]);
    hit = m_valid[i] && m_tag[i] == req_pc[31:8];
    ent.pc     = req_pc;
    ent.pred   = hit ? m_last[i] + m_stride[i] : 32'h0;
    ent.use_it = vp_en && hit && m_conf[i] >= 3;
    exp_pred_valid = do_push;
    exp_pred_use   = do_push && ent.use_it;
    exp_pred_data  = ent.pred;
    exp_en_recover = 0; exp_recover_data = '0; exp_done = 0;
    if (do_pop) begin
      p = mq.pop_front();
      if (p.use_it && res_data != p.pred) begin
        exp_en_recover = 1; exp_recover_data = res_data;
      end else exp_done = 1;
      modelTrain(p.pc, res_data);
    end
    if (do_push) mq.push_back(ent);
    if (flush) mq.delete();
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    bit exp_ready;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("pred_valid", pred_valid, exp_pred_valid);
        if (exp_pred_valid) begin
          checkOutput("pred_use", pred_use, exp_pred_use);
          checkOutput("pred_data", pred_data, exp_pred_data);
        end
        checkOutput("en_recover", en_recover, exp_en_recover);
        checkOutput("done", done, exp_done);
        if (exp_en_recover) checkOutput("recover_data", recover_data, exp_recover_data);
        exp_ready = mq.size() < 4 || (res_valid && mq.size() > 0 && !flush);
        checkOutput("req_ready", req_ready, exp_ready);
      end
    end
  end

  task automatic applyStimulus(input bit rv, input logic [31:0] pc, input bit sv,
                               input logic [31:0] rd, input bit fl, input bit vp);
    #1;
    req_valid = rv; req_pc = pc; res_valid = sv; res_data = rd; flush = fl; vp_en = vp;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReq(input logic [31:0] pc);
    applyStimulus(1, pc, 0, 0, 0, 1);
  endtask

  task automatic doRes(input logic [31:0] d);
    applyStimulus(0, 0, 1, d, 0, 1);
  endtask

  task automatic doIdle();
    applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int stride_seq[5] = '{10, 14, 18, 22, 26};
    repeat (2) @(negedge clk);
    checkOutput("rst_pred_valid", pred_valid, 0);
    checkOutput("rst_en_recover", en_recover, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    #1 rst_n = 1'b1;

    // Cold miss, then the allocated entry predicts its last value.
    doReq(32'h100);
    checkOutput("cold_pred_valid", pred_valid, 1);
    checkOutput("cold_pred_use", pred_use, 0);
    checkOutput("cold_pred_data", pred_data, 0);
    doRes(32'h55);
    checkOutput("cold_done", done, 1);
    checkOutput("cold_en_recover", en_recover, 0);
    doReq(32'h100);
    checkOutput("cold_last", pred_data, 32'h55);
    doRes(32'h55);

    // Stride learning on pc 0x200, two predictions in flight.
    foreach (stride_seq[k]) begin
      doReq(32'h200);
      doRes(stride_seq[k]);
    end
    doReq(32'h200);
    checkOutput("stride_pred_use", pred_use, 1);
    checkOutput("stride_pred_data", pred_data, 30);
    doReq(32'h200);
    doRes(30);
    checkOutput("stride_done", done, 1);
    doRes(99);
    checkOutput("mis_en_recover", en_recover, 1);
    checkOutput("mis_recover_data", recover_data, 99);
    checkOutput("mis_done", done, 0);
    doReq(32'h200);
    checkOutput("mis_new_stride_pred", pred_data, 168);
    checkOutput("mis_conf_cleared", pred_use, 0);
    doRes(168);

    // Full queue, then a simultaneous push and pop.
    for (int k = 0; k < 4; k++) doReq(32'h300 + 32'(k * 4));
    doIdle();
    checkOutput("full_ready", req_ready, 0);
    #1 req_valid = 1; req_pc = 32'h310; res_valid = 1; res_data = 32'h1;
    #1 checkOutput("full_ready_with_pop", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("full_push_pred_valid", pred_valid, 1);
    checkOutput("full_pop_done", done, 1);
    doIdle();
    checkOutput("full_still_full", req_ready, 0);
    for (int k = 0; k < 4; k++) doRes(32'(k));

    // Flush with three pending, plus a response against an empty queue.
    for (int k = 0; k < 3; k++) doReq(32'h500);
    applyStimulus(1, 32'h500, 1, 32'h7, 1, 1);
    checkOutput("flush_pred_valid", pred_valid, 0);
    checkOutput("flush_done", done, 0);
    checkOutput("flush_en_recover", en_recover, 0);
    doRes(32'h77);
    checkOutput("empty_res_done", done, 0);

    // vp_en low hides a confident prediction but training continues.
    for (int k = 0; k < 5; k++) begin
      doReq(32'h400);
      doRes(5);
    end
    applyStimulus(1, 32'h400, 0, 0, 0, 0);
    checkOutput("vpoff_pred_use", pred_use, 0);
    checkOutput("vpoff_pred_data", pred_data, 5);
    doRes(7);
    checkOutput("vpoff_done", done, 1);
    doReq(32'h400);
    checkOutput("vpoff_trained", pred_data, 9);
    doRes(9);

    // Asynchronous reset with two predictions pending.
    doReq(32'h600);
    doReq(32'h604);
    #1 req_valid = 0; res_valid = 0; flush = 0; rst_n = 1'b0;
    #1 checkOutput("arst_pred_valid", pred_valid, 0);
    checkOutput("arst_req_ready", req_ready, 1);
    checkOutput("arst_done", done, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    doReq(32'h400);
    checkOutput("arst_miss_use", pred_use, 0);
    checkOutput("arst_miss_data", pred_data, 0);
    doRes(32'h3);
    checkOutput("arst_done_after", done, 1);
    doIdle();
    doIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_value_predictor.md
LOAD_VALUE_PREDICTOR -- requirements
Module: load_value_predictor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter INDEX_WIDTH SHALL default to 6 and set the table size to 2^INDEX_WIDTH entries.
REQ-003 Parameter CONF_WIDTH SHALL default to 2 and set the saturating confidence counter width.
REQ-004 Parameter CONF_THRESH SHALL default to 3 and set the minimum confidence for a speculative prediction.
REQ-005 Parameter MAX_PENDING SHALL default to 4 and set the depth of the in-order pending-prediction queue (power of 2).
REQ-006 Parameter STRIDE_EN SHALL default to 1: 1 selects stride prediction, 0 selects last-value prediction.
REQ-007 Ports (name  direction  width  meaning):
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 vp_en  in  1  global speculation enable
 req_valid  in  1  load lookup request
 req_pc  in  ADDR_WIDTH  load PC
 req_ready  out  1  queue not full
 pred_valid  out  1  prediction result valid
 pred_use  out  1  confident; pipeline may consume pred_data
 pred_data  out  DATA_WIDTH  predicted value
 res_valid  in  1  actual load data returned (oldest pending)
 res_data  in  DATA_WIDTH  actual load value
 flush  in  1  discard all pending predictions
 en_recover  out  1  misprediction pulse
 recover_data  out  DATA_WIDTH  correct value, valid with en_recover
 done  out  1  resolved with no recovery needed

Function
REQ-008 Index SHALL be req_pc[INDEX_WIDTH+1:2]; tag SHALL be req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2].
REQ-009 Each entry SHALL hold valid, tag, last (DATA_WIDTH), stride (DATA_WIDTH), conf (CONF_WIDTH).
REQ-010 A request SHALL be accepted when req_valid && req_ready, and req_ready SHALL be the inverse of queue-full.
REQ-011 pred_valid, pred_use, and pred_data SHALL be registered and SHALL appear exactly 1 cycle after acceptance.
REQ-012 pred_data SHALL be last+stride (mod 2^DATA_WIDTH) when STRIDE_EN=1, otherwise last; it SHALL be 0 on a tag miss.
REQ-013 pred_use SHALL be vp_en && entry valid && tag match && conf>=CONF_THRESH.
REQ-014 Every accepted request SHALL push {index, tag, pred_data, pred_use} into the pending queue, whether or not pred_use is set.
REQ-015 res_valid SHALL pop the oldest pending entry and compare res_data against its prediction, and outputs SHALL be registered with 1-cycle latency.
REQ-016 If the popped entry has pred_use=1 and the data mismatches, the block SHALL pulse en_recover for 1 cycle with recover_data=res_data, and done SHALL stay 0.
REQ-017 Otherwise, on a match or on pred_use=0, the block SHALL pulse done for 1 cycle with en_recover=0.
REQ-018 Training on a tag miss or invalid entry SHALL allocate tag, last=res_data, stride=0, and conf=0.
REQ-019 Training on a tag hit SHALL compute new_stride=res_data-last (mod 2^DATA_WIDTH).
REQ-020 On a hit, if new_stride==stride, conf SHALL saturating-increment; else stride SHALL become new_stride and conf SHALL become 0; last SHALL become res_data.
REQ-021 When STRIDE_EN=0, the stride check SHALL be replaced by res_data==last.
REQ-022 A same-cycle req and res SHALL both proceed; a push SHALL be allowed while full if a pop occurs the same cycle, and req_ready SHALL reflect this.
REQ-023 A lookup SHALL read table state before any same-cycle training write, with no bypass.
REQ-024 res_valid with an empty queue SHALL be ignored, with no table update, done, or en_recover.
REQ-025 flush SHALL empty the queue next cycle, suppress same-cycle req and res effects, retain table contents, and never assert en_recover.
REQ-026 The queue pointers SHALL wrap modulo MAX_PENDING, with full and empty distinguished by an occupancy counter.

Reset
REQ-027 On rst_n low, the block SHALL immediately clear all table valid bits and conf counters and empty the queue.
REQ-028 On rst_n low, all outputs SHALL be 0 except req_ready, which SHALL be 1.
REQ-029 Reset mid-operation SHALL discard pending predictions without a recover or done pulse.

Verification
REQ-030 Cold miss: req pc=0x100, then res_data=0x55 -> pred_use=0, pred_data=0; done=1; entry last=0x55, conf=0.
REQ-031 Stride learning: pc=0x200 resolves 10,14,18,22,26 in sequence -> next request gives pred_use=1, pred_data=30; res 30 -> done=1.
REQ-032 Mispredict: after training, res_data=99 when 30 was predicted -> en_recover=1, recover_data=99, conf=0, stride=69.
REQ-033 Full queue: 4 requests without res -> req_ready=0; req+res in the same cycle -> accepted, occupancy stays 4.
REQ-034 Flush and vp_en: flush with 3 pending -> no pulses, queue empty; vp_en=0 with a confident entry -> pred_use=0 and training continues.
REQ-035 Async reset mid-stream: rst_n low with 2 pending -> outputs 0 and req_ready=1 at once; next lookup is a miss.
